// File: rtl/ascon_drv_pkg.sv
// ascon_drv_pkg: shared state encoding and byte-stream constants for the Ascon stream driver
package ascon_drv_pkg;
    typedef enum logic [3:0] {
        S_IDLE, S_GATHER, S_GATHER_TAG, S_LAUNCH, S_WAIT, S_CAPTURE, S_EMIT, S_EMIT_TAG, S_DROP
    } state_t;
    localparam int TAG_BYTES = 16;
    localparam int BYTE_W = 8;
endpackage

// File: rtl/ascon_stream_driver_byte_serializer.sv
// byte_serializer: parallel-load shift register that emits N bytes MSB first on a valid/ready port
module byte_serializer
    import ascon_drv_pkg::*;
#(
    parameter int N = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [N*BYTE_W-1:0] load_data,
    input  logic                ready,
    output logic                valid,
    output logic [BYTE_W-1:0]   data,
    output logic                last
);
    localparam int CW = $clog2(N + 1);
    logic [N*BYTE_W-1:0] sh;
    logic [CW-1:0]       cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= load_data;
            cnt <= CW'(N);
        end else if (valid && ready) begin
            sh  <= sh << BYTE_W;
            cnt <= cnt - CW'(1);
        end
    end
    assign valid = cnt != '0;
    assign data  = sh[N*BYTE_W-1 -: BYTE_W];
    assign last  = cnt == CW'(1);
endmodule

// File: rtl/ascon_stream_driver.sv
// ascon_stream_driver: byte-stream initiator for the Ascon core; gathers a block, launches the core,
// and streams back ciphertext+tag, or plaintext only when the expected tag matches in decrypt mode
module ascon_stream_driver
    import ascon_drv_pkg::*;
#(
    parameter int Y = 40,
    parameter int L = 40,
    parameter int K = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [K-1:0]          cfg_key,
    input  logic [127:0]          cfg_nonce,
    input  logic                  cfg_decrypt,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BYTE_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BYTE_W-1:0]     out_data,
    output logic                  auth_fail,
    output logic [15:0]           fail_count,
    output logic                  busy,
    output logic [K-1:0]          core_key,
    output logic [127:0]          core_nonce,
    output logic [L-1:0]          core_ad,
    output logic [Y-1:0]          core_data,
    output logic                  core_decrypt,
    output logic                  core_start,
    input  logic [Y-1:0]          core_out,
    input  logic [127:0]          core_tag,
    input  logic                  core_ready
);
    localparam int NB = Y / BYTE_W;
    localparam int TW = TAG_BYTES * BYTE_W;
    localparam int CW = $clog2((NB > TAG_BYTES ? NB : TAG_BYTES) + 1);
    state_t            state;
    logic [CW-1:0]     cnt;
    logic [39:0]       blk;
    logic [127:0]      nonce_r, exp_tag, tag_r;
    logic [Y-1:0]      out_r;
    logic              d_valid, d_last, d_load, d_fire, t_valid, t_last, t_load, t_fire, blk_end;
    logic [BYTE_W-1:0] d_data, t_data;
    assign in_ready  = state == S_GATHER || state == S_GATHER_TAG;
    assign busy      = state != S_IDLE;
    assign d_fire    = state == S_EMIT && d_valid && out_ready;
    assign t_fire    = state == S_EMIT_TAG && t_valid && out_ready;
    assign d_load    = state == S_CAPTURE && (!core_decrypt || tag_r == exp_tag);
    assign t_load    = d_fire && d_last && !core_decrypt;
    assign blk_end   = (d_fire && d_last && core_decrypt) || (t_fire && t_last) || state == S_DROP;
    assign out_valid = (state == S_EMIT && d_valid) || (state == S_EMIT_TAG && t_valid);
    assign out_data  = state == S_EMIT ? d_data : state == S_EMIT_TAG ? t_data : '0;
    byte_serializer #(.N(NB)) u_data_ser (
        .clk(clk), .rst(rst), .load(d_load), .load_data(out_r),
        .ready(state == S_EMIT && out_ready), .valid(d_valid), .data(d_data), .last(d_last)
    );
    byte_serializer #(.N(TAG_BYTES)) u_tag_ser (
        .clk(clk), .rst(rst), .load(t_load), .load_data(tag_r),
        .ready(state == S_EMIT_TAG && out_ready), .valid(t_valid), .data(t_data), .last(t_last)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            blk          <= '0;
            nonce_r      <= '0;
            exp_tag      <= '0;
            tag_r        <= '0;
            out_r        <= '0;
            core_key     <= '0;
            core_nonce   <= '0;
            core_ad      <= '0;
            core_data    <= '0;
            core_decrypt <= 1'b0;
            core_start   <= 1'b0;
            auth_fail    <= 1'b0;
            fail_count   <= '0;
        end else begin
            core_start <= 1'b0;
            auth_fail  <= 1'b0;
            // blk only moves at block end, so these hold steady from LAUNCH through CAPTURE
            core_nonce <= nonce_r + 128'(blk);
            core_ad    <= blk[L-1:0];
            case (state)
                S_IDLE: if (enable) begin
                    core_key     <= cfg_key;
                    nonce_r      <= cfg_nonce;
                    core_decrypt <= cfg_decrypt;
                    blk          <= '0;
                    cnt          <= '0;
                    state        <= S_GATHER;
                end
                S_GATHER: if (in_valid) begin
                    core_data <= Y'({core_data, in_data});
                    cnt       <= cnt == CW'(NB - 1) ? '0 : cnt + CW'(1);
                    if (cnt == CW'(NB - 1)) begin
                        state      <= core_decrypt ? S_GATHER_TAG : S_LAUNCH;
                        core_start <= !core_decrypt;
                    end
                end
                S_GATHER_TAG: if (in_valid) begin
                    exp_tag <= {exp_tag[TW-BYTE_W-1:0], in_data};
                    cnt     <= cnt == CW'(TAG_BYTES - 1) ? '0 : cnt + CW'(1);
                    if (cnt == CW'(TAG_BYTES - 1)) begin
                        state      <= S_LAUNCH;
                        core_start <= 1'b1;
                    end
                end
                S_LAUNCH: state <= S_WAIT;
                S_WAIT: if (core_ready) begin
                    out_r      <= core_out;
                    tag_r      <= core_tag;
                    core_start <= 1'b1;
                    state      <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    state     <= d_load ? S_EMIT : S_DROP;
                    auth_fail <= !d_load;
                end
                S_EMIT: if (t_load) state <= S_EMIT_TAG;
                S_EMIT_TAG: ;
                S_DROP: fail_count <= fail_count == 16'hFFFF ? fail_count : fail_count + 16'd1;
                default: state <= S_IDLE;
            endcase
            if (blk_end) begin
                blk   <= blk + 40'd1;
                state <= enable ? S_GATHER : S_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_ascon_stream_driver.sv
// tb_ascon_stream_driver: table-driven bench for the stream driver, with a toy cipher standing in
// for the Ascon core so every expected byte is derived from the bench's own model
module tb_ascon_stream_driver;
    logic         clk = 1'b0, rst = 1'b1, enable = 1'b0, bp = 1'b0;
    logic [127:0] cfg_key = '0, cfg_nonce = '0;
    logic         cfg_decrypt = 1'b0;
    logic         in_valid = 1'b0, in_ready;
    logic [7:0]   in_data = '0;
    logic         out_valid, out_ready = 1'b1;
    logic [7:0]   out_data;
    logic         auth_fail, busy;
    logic [15:0]  fail_count;
    logic [127:0] core_key, core_nonce, core_tag;
    logic [39:0]  core_ad, core_data, core_out;
    logic         core_decrypt, core_start, core_ready;
    int n_vec = 0, n_err = 0, n_start = 0, n_auth = 0;
    logic [7:0] oq[$];

    ascon_stream_driver dut (
        .clk(clk), .rst(rst), .enable(enable), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce),
        .cfg_decrypt(cfg_decrypt), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .auth_fail(auth_fail),
        .fail_count(fail_count), .busy(busy), .core_key(core_key), .core_nonce(core_nonce),
        .core_ad(core_ad), .core_data(core_data), .core_decrypt(core_decrypt),
        .core_start(core_start), .core_out(core_out), .core_tag(core_tag), .core_ready(core_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] ks_f(input logic [127:0] key, input logic [127:0] n);
        return (n[39:0] ^ key[39:0] ^ n[127:88]) * 40'd2654435761 + 40'h0123456789;
    endfunction

    function automatic logic [127:0] tag_f(input logic [127:0] key, input logic [127:0] n,
                                           input logic [39:0] ad, input logic [39:0] pt);
        return n ^ key ^ {ad, 48'h0, pt} ^ 128'h5A5A5A5A_0F1E2D3C_4B5A6978_8796A5B4;
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // toy core: latches inputs on start, answers 4 cycles later, holds ready until the ack pulse
    logic         m_busy, m_dec;
    int           m_wait;
    logic [127:0] m_key, m_nonce;
    logic [39:0]  m_ad, m_data;
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_wait <= 0; core_ready <= 1'b0; core_out <= '0; core_tag <= '0;
            m_key <= '0; m_nonce <= '0; m_ad <= '0; m_data <= '0; m_dec <= 1'b0;
        end else if (!m_busy) begin
            if (core_start) begin
                m_busy <= 1'b1; m_wait <= 3; m_key <= core_key; m_nonce <= core_nonce;
                m_ad <= core_ad; m_data <= core_data; m_dec <= core_decrypt;
            end
        end else if (!core_ready) begin
            if (m_wait == 0) begin
                core_ready <= 1'b1;
                core_out   <= m_data ^ ks_f(m_key, m_nonce);
                core_tag   <= tag_f(m_key, m_nonce, m_ad, m_dec ? m_data ^ ks_f(m_key, m_nonce) : m_data);
            end else m_wait <= m_wait - 1;
        end else if (core_start) begin
            core_ready <= 1'b0; core_tag <= '0; m_busy <= 1'b0;
        end
    end

    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (prev_stall) check("stall_hold", {out_valid, out_data}, {1'b1, prev_data});
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid) begin
                check("in_ready_while_emit", in_ready, 1'b0);
                if (out_ready) oq.push_back(out_data);
            end
            if (auth_fail) n_auth++;
            if (core_start) n_start++;
        end
    end

    initial forever begin
        @(posedge clk);
        #1 out_ready = bp ? !out_ready : 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic         start, dec, keep, bp;
        logic [127:0] key, nonce;
        logic [39:0]  data;
        logic [127:0] tag, exp_nonce;
        logic [39:0]  exp_ad, exp_pt;
        int           exp_auth;
        logic [15:0]  exp_fc;
    } vec_t;
    vec_t tbl[7];

    task automatic send_byte(input logic [7:0] b);
        int   t;
        logic acc;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        do begin
            @(negedge clk);
            acc = in_ready;
            t++;
            @(posedge clk);
            #1;
        end while (!acc && t < 200);
        check("in_accept", acc, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic reset_checks(input string nm);
        check({nm, " ctrl"}, {in_ready, out_valid, out_data, core_start, auth_fail, fail_count, busy, core_decrypt}, '0);
        check({nm, " core_key"}, core_key, '0);
        check({nm, " core_nonce"}, core_nonce, '0);
        check({nm, " core_ad_data"}, {core_ad, core_data}, '0);
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        logic [39:0]  got_d, exp_d;
        logic [127:0] got_t;
        int exp_n, t;
        oq.delete();
        n_start = 0;
        n_auth  = 0;
        bp = v.bp;
        if (v.start) begin
            cfg_key = v.key; cfg_nonce = v.nonce; cfg_decrypt = v.dec; enable = 1'b1;
        end
        for (int i = 0; i < 5; i++) begin
            send_byte(v.data[39-8*i -: 8]);
            if (i == 0 && !v.keep) enable = 1'b0;
        end
        if (v.dec) for (int i = 0; i < 16; i++) send_byte(v.tag[127-8*i -: 8]);
        check({nm, " start_latency"}, core_start, 1'b1);
        exp_n = v.dec ? (v.exp_auth != 0 ? 0 : 5) : 21;
        t = 0;
        while ((oq.size() < exp_n || n_start < 2 || n_auth < v.exp_auth) && t < 600) begin
            @(posedge clk);
            #1 t++;
        end
        check({nm, " done_in_time"}, t < 600, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        bp = 1'b0;
        check({nm, " core_key"}, m_key, v.key);
        check({nm, " core_nonce"}, m_nonce, v.exp_nonce);
        check({nm, " core_ad"}, m_ad, v.exp_ad);
        check({nm, " core_data"}, m_data, v.data);
        check({nm, " core_decrypt"}, m_dec, v.dec);
        check({nm, " start_cycles"}, n_start, 2);
        check({nm, " auth_pulses"}, n_auth, v.exp_auth);
        check({nm, " fail_count"}, fail_count, v.exp_fc);
        check({nm, " out_bytes"}, oq.size(), exp_n);
        check({nm, " busy_after"}, busy, v.keep);
        if (exp_n != 0 && oq.size() >= exp_n) begin
            got_d = '0;
            for (int i = 0; i < 5; i++) got_d = {got_d[31:0], oq[i]};
            exp_d = v.dec ? v.exp_pt : v.data ^ ks_f(v.key, v.exp_nonce);
            check({nm, " out_data"}, got_d, exp_d);
            if (exp_n == 21) begin
                got_t = '0;
                for (int i = 5; i < 21; i++) got_t = {got_t[119:0], oq[i]};
                check({nm, " out_tag"}, got_t, tag_f(v.key, v.exp_nonce, v.exp_ad, v.data));
            end
        end
    endtask

    initial begin
        logic [39:0]  ct0;
        logic [127:0] tag0;
        ct0  = 40'h0102030405 ^ ks_f('0, '0);
        tag0 = tag_f('0, '0, 40'h0, 40'h0102030405);
        tbl[0] = '{start:1, dec:0, keep:1, bp:0, key:'0, nonce:'0, data:40'h0102030405, tag:'0,
                   exp_nonce:'0, exp_ad:40'h0, exp_pt:'0, exp_auth:0, exp_fc:16'h0};
        tbl[1] = '{start:0, dec:0, keep:0, bp:0, key:'0, nonce:'0, data:40'h0102030405, tag:'0,
                   exp_nonce:128'h1, exp_ad:40'h1, exp_pt:'0, exp_auth:0, exp_fc:16'h0};
        tbl[2] = '{start:1, dec:1, keep:0, bp:0, key:'0, nonce:'0, data:ct0, tag:tag0,
                   exp_nonce:'0, exp_ad:40'h0, exp_pt:40'h0102030405, exp_auth:0, exp_fc:16'h0};
        tbl[3] = '{start:1, dec:1, keep:0, bp:0, key:'0, nonce:'0, data:ct0,
                   tag:tag0 ^ {56'h0, 8'h01, 64'h0},
                   exp_nonce:'0, exp_ad:40'h0, exp_pt:'0, exp_auth:1, exp_fc:16'h1};
        tbl[4] = '{start:1, dec:0, keep:1, bp:1, key:'0, nonce:'1, data:40'hAABBCCDDEE, tag:'0,
                   exp_nonce:'1, exp_ad:40'h0, exp_pt:'0, exp_auth:0, exp_fc:16'h1};
        tbl[5] = '{start:0, dec:0, keep:0, bp:1, key:'0, nonce:'1, data:40'hAABBCCDDEE, tag:'0,
                   exp_nonce:'0, exp_ad:40'h1, exp_pt:'0, exp_auth:0, exp_fc:16'h1};
        tbl[6] = '{start:1, dec:0, keep:0, bp:0, key:128'h0F0E0D0C_0B0A0908_07060504_03020100,
                   nonce:128'h5, data:40'h2122232425, tag:'0,
                   exp_nonce:128'h5, exp_ad:40'h0, exp_pt:'0, exp_auth:0, exp_fc:16'h0};
        repeat (2) @(posedge clk);
        #1 reset_checks("reset");
        rst = 1'b0;
        for (int i = 0; i < 6; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
        // abort a block while the driver is waiting on the core
        cfg_key = tbl[6].key; cfg_nonce = tbl[6].nonce; cfg_decrypt = 1'b0; enable = 1'b1;
        for (int i = 0; i < 5; i++) send_byte(8'h11 + 8'(i));
        @(posedge clk);
        #1 check("wait_state", {busy, core_start, core_ready}, 3'b100);
        rst = 1'b1;
        enable = 1'b0;
        #1 reset_checks("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        run_vec(tbl[6], "post_reset");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
